// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
// NOP_INST and INVALID_PC mirror the values the fetch unit already uses for bubbles.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_IF   = 2'd1,
        R_LS   = 2'd2,
        R_ERR  = 2'd3
    } resp_state_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] INVALID_PC = 32'hFFFF_FFFF;

    // Wide enough for any streak limit in 1..15.
    localparam int STREAK_W = 4;

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_streak_counter.sv
// Saturating count of back-to-back LS grants taken while fetch was also asking.
// lt_max low means fetch must be served next.
module arb_streak_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc,
    input  logic clr,
    output logic lt_max
);

    localparam logic [STREAK_W-1:0] MAX_CNT = STREAK_W'(MAX);

    logic [STREAK_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt < MAX_CNT)) begin
            cnt <= cnt + STREAK_W'(1);
        end
    end

    assign lt_max = (cnt < MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous-read memory between fetch and load/store.
// Data has priority; a streak guard bounds how long fetch can be held off.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  R_NONE | no read response this cycle
//  R_IF   | memory data this cycle belongs to fetch (pc in pc_q)
//  R_LS   | memory data this cycle belongs to load/store
//  R_ERR  | misaligned LS access granted last cycle; report error
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ILEN          = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_pc,
    input  logic            i_if_flush,
    output logic [ILEN-1:0] o_if_inst,
    output logic [XLEN-1:0] o_if_addr,
    output logic            o_if_wait,

    input  logic            i_ls_req,
    input  logic            i_ls_we,
    input  logic [XLEN-1:0] i_ls_addr,
    input  logic [XLEN-1:0] i_ls_wdata,
    input  logic [3:0]      i_ls_wstrb,
    output logic            o_ls_gnt,
    output logic            o_ls_rvalid,
    output logic [XLEN-1:0] o_ls_rdata,
    output logic            o_ls_err,

    output logic            o_mem_en,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_wstrb,
    input  logic [XLEN-1:0] i_mem_rdata
);

    logic        ls_mis;
    logic        ls_win;
    logic        if_win;
    logic        lt_max;
    logic        streak_inc;
    logic        streak_clr;

    resp_state_t     resp_state;
    resp_state_t     resp_next;
    logic [XLEN-1:0] pc_q;

    // Grants are forced off while reset is held so nothing reaches memory.
    always_comb begin
        ls_mis = i_ls_req & is_misaligned(i_ls_addr[1:0]);
        ls_win = rstn & i_ls_req & (~i_if_req | lt_max);
        if_win = rstn & i_if_req & ~ls_win;
    end

    assign o_ls_gnt  = ls_win;
    assign o_if_wait = i_if_req & ~if_win;

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wstrb = 4'b0000;
        if (if_win) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_if_pc;
        end else if (ls_win && !ls_mis) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_ls_we;
            o_mem_addr  = i_ls_addr;
            o_mem_wdata = i_ls_wdata;
            o_mem_wstrb = i_ls_wstrb;
        end
    end

    assign streak_inc = ls_win & i_if_req;
    assign streak_clr = if_win | ~i_if_req;

    arb_streak_counter #(
        .MAX (MAX_LS_STREAK)
    ) u_streak (
        .clk    (clk),
        .rstn   (rstn),
        .inc    (streak_inc),
        .clr    (streak_clr),
        .lt_max (lt_max)
    );

    // A flush in the grant cycle still reads memory but drops the response.
    always_comb begin
        resp_next = R_NONE;
        if (if_win && !i_if_flush) begin
            resp_next = R_IF;
        end else if (ls_win && ls_mis) begin
            resp_next = R_ERR;
        end else if (ls_win && !i_ls_we) begin
            resp_next = R_LS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_state <= R_NONE;
            pc_q       <= XLEN'(INVALID_PC);
        end else begin
            resp_state <= resp_next;
            if (resp_next == R_IF) begin
                pc_q <= i_if_pc;
            end
        end
    end

    always_comb begin
        o_if_inst   = ILEN'(NOP_INST);
        o_if_addr   = XLEN'(INVALID_PC);
        o_ls_rvalid = 1'b0;
        o_ls_rdata  = '0;
        o_ls_err    = 1'b0;
        case (resp_state)
            R_IF: begin
                o_if_inst = i_mem_rdata[ILEN-1:0];
                o_if_addr = pc_q;
            end
            R_LS: begin
                o_ls_rvalid = 1'b1;
                o_ls_rdata  = i_mem_rdata;
            end
            R_ERR: begin
                o_ls_rvalid = 1'b1;
                o_ls_err    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of grants, streak limit and tagged responses.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_if_req, i_if_flush;
    logic [31:0] i_if_pc;
    logic [31:0] o_if_inst, o_if_addr;
    logic        o_if_wait;
    logic        i_ls_req, i_ls_we;
    logic [31:0] i_ls_addr, i_ls_wdata;
    logic [3:0]  i_ls_wstrb;
    logic        o_ls_gnt, o_ls_rvalid, o_ls_err;
    logic [31:0] o_ls_rdata;
    logic        o_mem_en, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] i_mem_rdata;

    mem_port_arbiter #(
        .XLEN(32), .ILEN(32), .MAX_LS_STREAK(MAX)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_if_req(i_if_req), .i_if_pc(i_if_pc), .i_if_flush(i_if_flush),
        .o_if_inst(o_if_inst), .o_if_addr(o_if_addr), .o_if_wait(o_if_wait),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_wstrb(i_ls_wstrb),
        .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
        .o_ls_err(o_ls_err),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro stand-in: one-cycle read latency, byte-enabled writes.
    logic [31:0] mem [256];
    logic [31:0] mem_rdata_q;
    assign i_mem_rdata = mem_rdata_q;

    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (o_mem_wstrb[b]) mem[o_mem_addr[9:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            end else begin
                mem_rdata_q <= mem[o_mem_addr[9:2]];
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [256];
    int          m_streak;
    int          p_kind;       // 0 nothing, 1 fetch data, 2 LS data, 3 LS error
    logic [31:0] p_addr, p_data;
    int          wait_run;

    int total = 0;
    int bad   = 0;

    logic        last_gnt;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic step(input logic r, input logic ir, input logic [31:0] pc, input logic fl,
                        input logic lr, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
        logic e_mis, e_ls, e_if, e_en;
        rstn = r; i_if_req = ir; i_if_pc = pc; i_if_flush = fl;
        i_ls_req = lr; i_ls_we = we; i_ls_addr = a; i_ls_wdata = wd; i_ls_wstrb = ws;

        e_mis = lr && (a[1:0] != 2'b00);
        e_ls  = r && lr && (!ir || m_streak < MAX);
        e_if  = r && ir && !e_ls;
        e_en  = e_if || (e_ls && !e_mis);

        @(negedge clk);
        chk("ls_gnt",  o_ls_gnt,  e_ls);
        chk("if_wait", o_if_wait, ir && !e_if);
        chk("mem_en",  o_mem_en,  e_en);
        if (e_if) begin
            chk("if_addr_out", o_mem_addr, pc);
            chk("if_we", o_mem_we, 1'b0);
            chk("if_wstrb", o_mem_wstrb, 4'b0000);
        end else if (e_en) begin
            chk("ls_addr_out", o_mem_addr, a);
            chk("ls_we", o_mem_we, we);
            if (we) begin
                chk("ls_wdata", o_mem_wdata, wd);
                chk("ls_wstrb", o_mem_wstrb, ws);
            end
        end

        chk("rvalid", o_ls_rvalid, p_kind == 2 || p_kind == 3);
        chk("ls_err", o_ls_err, p_kind == 3);
        chk("ls_rdata", o_ls_rdata, (p_kind == 2) ? p_data : 32'h0);
        chk("if_inst", o_if_inst, (p_kind == 1) ? p_data : NOP_INST);
        chk("if_addr", o_if_addr, (p_kind == 1) ? p_addr : INVALID_PC);

        if (r && ir && o_if_wait) wait_run++;
        else wait_run = 0;
        if (r && ir) chk("guard", wait_run <= MAX, 1'b1);

        last_gnt   = o_ls_gnt;
        last_rdata = o_ls_rdata;

        @(posedge clk);
        if (!r) begin
            m_streak = 0;
            p_kind   = 0;
        end else begin
            if (e_if && !fl) begin
                p_kind = 1; p_addr = pc; p_data = ref_mem[pc[9:2]];
            end else if (e_ls && e_mis) begin
                p_kind = 3;
            end else if (e_ls && !we) begin
                p_kind = 2; p_data = ref_mem[a[9:2]];
            end else begin
                p_kind = 0;
            end
            if (e_ls && !e_mis && we)
                for (int b = 0; b < 4; b++)
                    if (ws[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
            if (e_ls && ir) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
            else m_streak = 0;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            mem[i] = w;
            ref_mem[i] = w;
        end
        mem_rdata_q = 32'h0;
        m_streak = 0; p_kind = 0; p_addr = 0; p_data = 0; wait_run = 0;

        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Plain fetch, then its response.
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle();

        // LS read beats fetch at streak 0.
        step(1'b1, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        idle();

        // Held LS requests against fetch: fifth cycle must go to fetch.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 32'h200 + 32'(4*i), 32'h0, 4'h0);
            chk("streak_pattern", last_gnt, i != 4);
        end
        idle();

        // Partial write then readback of low half.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h300, 32'hDEADBEEF, 4'b0011);
        idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        idle();
        chk("write_low_half", last_rdata[15:0], 16'hBEEF);

        // Misaligned access.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h202, 32'h0, 4'h0);
        idle();

        // Flush in the grant cycle.
        step(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle();

        // Reset while an LS response is pending.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 4'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle();

        for (int n = 0; n < 3000; n++) begin
            logic        r, ir, fl, lr, we;
            logic [31:0] pc, a, wd;
            logic [3:0]  ws;
            r  = ($urandom_range(0, 99) >= 2);
            ir = ($urandom_range(0, 99) < 70);
            fl = ($urandom_range(0, 99) < 10);
            lr = ($urandom_range(0, 99) < 60);
            we = ($urandom_range(0, 99) < 40);
            pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            a  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 99) < 15) a[1:0] = 2'($urandom_range(1, 3));
            wd = $urandom;
            ws = 4'($urandom);
            step(r, ir, pc, fl, lr, we, a, wd, ws);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read memory between the Fetch_Unit (instruction reads) and the load/store path (data reads/writes).
- Per-cycle arbitration: data has priority, with a starvation guard for fetch.
- Tags each 1-cycle-latency read response with its owner and returns it on the matching port.
- Sits between Fetch_Unit/LSU and the memory macro. Fetch's `o_mem_pc`/`i_mem_inst`/`i_mem_addr` connect here; `o_if_wait` is ORed into fetch's stall.

Parameters:
- XLEN, 32, address/data width
- ILEN, 32, instruction width
- MAX_LS_STREAK, 4, max consecutive LS grants while fetch is requesting (range 1..15)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_if_req  in  1  fetch wants memory this cycle (= not stalled)
- i_if_pc  in  XLEN  fetch address
- i_if_flush  in  1  execute flush; kills in-flight fetch response
- o_if_inst  out  ILEN  fetched instruction
- o_if_addr  out  XLEN  address of o_if_inst, or `invalid_pc` for a bubble
- o_if_wait  out  1  fetch not granted this cycle; fetch holds pc
- i_ls_req  in  1  data request
- i_ls_we  in  1  1 = write
- i_ls_addr  in  XLEN  data address
- i_ls_wdata  in  XLEN  write data
- i_ls_wstrb  in  4  byte write enables
- o_ls_gnt  out  1  request accepted this cycle
- o_ls_rvalid  out  1  read data / error valid
- o_ls_rdata  out  XLEN  read data
- o_ls_err  out  1  misaligned access
- o_mem_en  out  1  memory enable
- o_mem_we  out  1  memory write
- o_mem_addr  out  XLEN  memory address
- o_mem_wdata  out  XLEN  memory write data
- o_mem_wstrb  out  4  memory byte enables
- i_mem_rdata  in  XLEN  memory read data, valid one cycle after a read

Behaviour:
- All state updates on posedge clk. Reset is synchronous: `!rstn` sampled at an edge overrides everything.
- Reset values (registered state):
  - resp_state=R_NONE, streak=0
  - o_if_inst=`nop`, o_if_addr=`invalid_pc`
  - o_ls_rvalid=0, o_ls_rdata=0, o_ls_err=0
- While rstn low (combinational outputs): o_mem_en=0, o_ls_gnt=0, o_if_wait=i_if_req.
- Misaligned access: ls_mis = i_ls_req & (i_ls_addr[1:0]!=0). It is granted but never reaches memory.
- Grant decision, combinational in cycle N:
  - LS wins if i_ls_req & (!i_if_req | streak<MAX_LS_STREAK).
  - Otherwise IF wins if i_if_req.
  - Otherwise idle.
- Port outputs in cycle N:
  - o_ls_gnt = LS wins.
  - o_if_wait = i_if_req & !IF wins.
- Memory outputs in cycle N:
  - IF wins: en=1, we=0, addr=i_if_pc, wstrb=0.
  - LS wins and !ls_mis: en=1, we=i_ls_we, addr/wdata/wstrb from LS.
  - Otherwise: en=0.
- Streak counter:
  - LS wins while i_if_req: +1.
  - IF wins, or !i_if_req: reset to 0.
  - Saturates at MAX_LS_STREAK.
- Guard guarantee: fetch waits at most MAX_LS_STREAK consecutive cycles.
- Response FSM (resp_state, next value set at edge N→N+1):
  - IF read issued & !i_if_flush → R_IF (latch i_if_pc).
  - LS read issued → R_LS.
  - ls_mis → R_ERR.
  - LS write, idle, or IF killed by flush → R_NONE.
- Cycle N+1 outputs (combinational from resp_state and i_mem_rdata):
  - R_IF: o_if_inst=i_mem_rdata[ILEN-1:0], o_if_addr=latched pc.
  - Not R_IF: o_if_inst=`nop`, o_if_addr=`invalid_pc`.
  - R_LS: o_ls_rvalid=1, o_ls_rdata=i_mem_rdata, o_ls_err=0.
  - R_ERR: o_ls_rvalid=1, o_ls_rdata=0, o_ls_err=1.
  - R_NONE: o_ls_rvalid=0, o_ls_rdata=0, o_ls_err=0.
- Writes: complete at the grant cycle; no rvalid.
- Flush with an IF response already in R_IF: that response is still delivered. Fetch discards it by its own flush handling.
- Simultaneous i_if_flush and IF grant: memory is read, response suppressed (bubble in N+1).
- Reset mid-transaction: a pending R_IF/R_LS is dropped; no rvalid after reset.

Decomposition:
- Shared package (alongside macros.hv): resp_state encoding (R_NONE=2'd0, R_IF=2'd1, R_LS=2'd2, R_ERR=2'd3). `nop` and `invalid_pc` are reused from macros.hv.
- One natural sub-module: arb_streak_counter (saturating counter with inc/clear and MAX parameter, output lt_max).

Test Plan:
- Reset then i_if_req=1, pc=0x100, no LS → mem addr 0x100 in cycle 0; cycle 1 o_if_inst=mem[0x100], o_if_addr=0x100, o_if_wait=0 throughout.
- LS read 0x200 while fetch requests (streak=0) → o_ls_gnt=1, o_if_wait=1; next cycle o_ls_rvalid=1 with mem[0x200], o_if_addr=`invalid_pc`.
- LS requests held for 6 cycles, MAX_LS_STREAK=4, fetch requesting → LS granted cycles 0-3, IF granted cycle 4 (o_ls_gnt=0), LS granted cycle 5.
- LS write 0x300, wdata 0xDEADBEEF, wstrb 4'b0011 → o_mem_we=1, wstrb=0011 same cycle; no rvalid; later read returns low half 0xBEEF.
- LS read at 0x202 → o_ls_gnt=1, o_mem_en=0 (fetch idle); next cycle o_ls_rvalid=1, o_ls_err=1, o_ls_rdata=0.
- IF grant with i_if_flush=1 at pc 0x104 → next cycle o_if_inst=`nop`, o_if_addr=`invalid_pc`. Also: rstn low during pending R_LS → no rvalid, outputs at reset values.
